// File: rtl/multadd_pkg.sv
// Shared types and constants for the multiply-add accumulator slice.
package multadd_pkg;

  localparam int DATA_W    = 17;
  localparam int LEN_DEF   = 16;
  localparam int ACC_W_DEF = 21;
  localparam int CNT_W_DEF = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Smallest accumulator that cannot overflow when summing len terms of data_w bits.
  function automatic int acc_width(input int data_w, input int len);
    return data_w + $clog2(len);
  endfunction

endpackage

// File: rtl/multadd_acc_outreg.sv
// Single-entry valid/ready result register; a result that arrives while the
// previous one is still unconsumed is discarded and flagged on drop_o.
module multadd_acc_outreg #(
  parameter int ACC_W = multadd_pkg::ACC_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [ACC_W-1:0] data_i,
  input  logic             sat_i,
  input  logic             ready_i,
  output logic [ACC_W-1:0] result_o,
  output logic             valid_o,
  output logic             drop_o,
  output logic             sat_o
);

  logic [ACC_W-1:0] result_q, result_d;
  logic             valid_q, valid_d;
  logic             drop_q, drop_d;
  logic             sat_q, sat_d;

  // A load is accepted when the slot is empty or is being drained this same cycle.
  always_comb begin
    result_d = result_q;
    valid_d  = valid_q;
    drop_d   = drop_q;
    sat_d    = sat_q;
    if (load_i) begin
      if (valid_q && !ready_i) begin
        drop_d = 1'b1;
      end else begin
        result_d = data_i;
        sat_d    = sat_i;
        valid_d  = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_q <= '0;
      valid_q  <= 1'b0;
      drop_q   <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
      drop_q   <= drop_d;
      sat_q    <= sat_d;
    end
  end

  assign result_o = result_q;
  assign valid_o  = valid_q;
  assign drop_o   = drop_q;
  assign sat_o    = sat_q;

endmodule

// File: rtl/multadd_accumulator.sv
// Accumulates LEN consecutive valid terms into one dot product per frame.
// Define MULTADD_ACC_SAT_EN to clamp sums at 2^ACC_W-1 and report it on oSAT.
module multadd_accumulator #(
  parameter int DATA_W = multadd_pkg::DATA_W,
  parameter int LEN    = multadd_pkg::LEN_DEF,
  parameter int ACC_W  = multadd_pkg::acc_width(DATA_W, LEN),
  parameter int CNT_W  = multadd_pkg::CNT_W_DEF
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iVALID,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iCLEAR,
  input  logic              iREADY,
  output logic [ACC_W-1:0]  oRESULT,
  output logic              oVALID,
  output logic              oBUSY,
  output logic              oDROP,
  output logic              oSAT
);

  import multadd_pkg::*;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] addSum;
  logic             lastTerm;
  logic             frameDone;
  logic             frameSat;

  // acc_q is zero whenever the FSM sits in IDLE, so the first term needs no mux.
  assign lastTerm = (cnt_q == CNT_W'(LEN - 1));

`ifdef MULTADD_ACC_SAT_EN
  logic [ACC_W:0] sumWide;
  logic           addOvf;
  logic           satAcc_q, satAcc_d;

  assign sumWide  = {1'b0, acc_q} + {1'b0, ACC_W'(iDATA)};
  assign addOvf   = sumWide[ACC_W];
  assign addSum   = addOvf ? '1 : sumWide[ACC_W-1:0];
  assign frameSat = satAcc_q | addOvf;

  always_comb begin
    satAcc_d = satAcc_q;
    if (iCLEAR || frameDone) begin
      satAcc_d = 1'b0;
    end else if (iVALID) begin
      satAcc_d = frameSat;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      satAcc_q <= 1'b0;
    end else begin
      satAcc_q <= satAcc_d;
    end
  end
`else
  assign addSum   = acc_q + ACC_W'(iDATA);
  assign frameSat = 1'b0;
`endif

  // Clear outranks a term in the same cycle and also suppresses its completion.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    frameDone = 1'b0;
    if (iCLEAR) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (iVALID) begin
      if (lastTerm) begin
        frameDone = 1'b1;
        state_d   = IDLE;
        acc_d     = '0;
        cnt_d     = '0;
      end else begin
        state_d = ACCUM;
        acc_d   = addSum;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign oBUSY = (state_q == ACCUM);

  multadd_acc_outreg #(
    .ACC_W(ACC_W)
  ) u_outreg (
    .clk_i   (iCLK),
    .rst_i   (iRST),
    .load_i  (frameDone),
    .data_i  (addSum),
    .sat_i   (frameSat),
    .ready_i (iREADY),
    .result_o(oRESULT),
    .valid_o (oVALID),
    .drop_o  (oDROP),
    .sat_o   (oSAT)
  );

endmodule

// File: tb/tb_multadd_accumulator.sv
// Bench for multadd_accumulator: two instances (ACC_W 21 and 18, LEN 4) share one stimulus stream.
// Honours MULTADD_ACC_SAT_EN when the build defines it.
module tb_multadd_accumulator;

  localparam int LEN = 4;
  localparam int WA  = 21;
  localparam int WB  = 18;

  logic        iCLK;
  logic        iRST;
  logic        iVALID;
  logic [16:0] iDATA;
  logic        iCLEAR;
  logic        iREADY;

  logic [WA-1:0] resA;
  logic [WB-1:0] resB;
  logic validA, busyA, dropA, satA;
  logic validB, busyB, dropB, satB;

  int passCount  = 0;
  int checkCount = 0;

  multadd_accumulator #(.DATA_W(17), .LEN(LEN), .ACC_W(WA), .CNT_W(16)) dutA (
    .iCLK(iCLK), .iRST(iRST), .iVALID(iVALID), .iDATA(iDATA), .iCLEAR(iCLEAR), .iREADY(iREADY),
    .oRESULT(resA), .oVALID(validA), .oBUSY(busyA), .oDROP(dropA), .oSAT(satA)
  );

  multadd_accumulator #(.DATA_W(17), .LEN(LEN), .ACC_W(WB), .CNT_W(16)) dutB (
    .iCLK(iCLK), .iRST(iRST), .iVALID(iVALID), .iDATA(iDATA), .iCLEAR(iCLEAR), .iREADY(iREADY),
    .oRESULT(resB), .oVALID(validB), .oBUSY(busyB), .oDROP(dropB), .oSAT(satB)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end else begin
      passCount++;
    end
  endtask

  // Frame-level model: sum the raw terms of each frame with unbounded arithmetic,
  // then reduce the finished total to the output width (wrap or clamp).
  function automatic longint unsigned reduceSum(input longint unsigned total, input int w);
    longint unsigned maxVal;
    maxVal = (64'd1 << w) - 64'd1;
`ifdef MULTADD_ACC_SAT_EN
    return (total > maxVal) ? maxVal : total;
`else
    return total & maxVal;
`endif
  endfunction

  function automatic bit satOf(input longint unsigned total, input int w);
`ifdef MULTADD_ACC_SAT_EN
    return total > ((64'd1 << w) - 64'd1);
`else
    return (total == 64'd0) && (w < 0);
`endif
  endfunction

  longint unsigned frameSum;
  int              frameCnt;
  bit              modelLive = 1'b0;
  bit              mValid, mDrop;
  longint unsigned mResA, mResB;
  bit              mSatA, mSatB;

  always @(posedge iCLK) begin
    bit              done;
    longint unsigned doneSum;
    done    = 1'b0;
    doneSum = 0;
    if (iRST) begin
      modelLive = 1'b1;
      frameSum  = 0;
      frameCnt  = 0;
      mValid    = 1'b0;
      mDrop     = 1'b0;
      mResA     = 0;
      mResB     = 0;
      mSatA     = 1'b0;
      mSatB     = 1'b0;
    end else if (modelLive) begin
      if (iCLEAR) begin
        frameSum = 0;
        frameCnt = 0;
      end else if (iVALID) begin
        frameSum += 64'(iDATA);
        frameCnt++;
        if (frameCnt == LEN) begin
          done     = 1'b1;
          doneSum  = frameSum;
          frameSum = 0;
          frameCnt = 0;
        end
      end
      if (done) begin
        if (mValid && !iREADY) begin
          mDrop = 1'b1;
        end else begin
          mValid = 1'b1;
          mResA  = reduceSum(doneSum, WA);
          mResB  = reduceSum(doneSum, WB);
          mSatA  = satOf(doneSum, WA);
          mSatB  = satOf(doneSum, WB);
        end
      end else if (mValid && iREADY) begin
        mValid = 1'b0;
      end
    end
  end

  always @(negedge iCLK) begin
    if (modelLive) begin
      checkOutput("A oRESULT", 64'(resA), mResA);
      checkOutput("A oVALID", 64'(validA), 64'(mValid));
      checkOutput("A oBUSY", 64'(busyA), 64'(frameCnt != 0));
      checkOutput("A oDROP", 64'(dropA), 64'(mDrop));
      checkOutput("A oSAT", 64'(satA), 64'(mSatA));
      checkOutput("B oRESULT", 64'(resB), mResB);
      checkOutput("B oVALID", 64'(validB), 64'(mValid));
      checkOutput("B oBUSY", 64'(busyB), 64'(frameCnt != 0));
      checkOutput("B oDROP", 64'(dropB), 64'(mDrop));
      checkOutput("B oSAT", 64'(satB), 64'(mSatB));
    end
  end

  // Drives one cycle of inputs and returns just after the edge that consumed them.
  task automatic applyStimulus(input bit v, input logic [16:0] d, input bit c, input bit r);
    iVALID = v;
    iDATA  = d;
    iCLEAR = c;
    iREADY = r;
    @(posedge iCLK);
    #1;
  endtask

  longint unsigned expB;
  bit              expSatB;

  initial begin
    iRST   = 1'b1;
    iVALID = 1'b0;
    iDATA  = '0;
    iCLEAR = 1'b0;
    iREADY = 1'b1;
    repeat (2) @(posedge iCLK);
    #1;
    iRST = 1'b0;
    checkOutput("reset oRESULT", 64'(resA), 0);
    checkOutput("reset oVALID", 64'(validA), 0);

    $display("[TB] frame 1,2,3,4 with ready high");
    applyStimulus(1, 17'd1, 0, 1);
    checkOutput("t1 busy after first term", 64'(busyA), 1);
    checkOutput("t1 valid low mid-frame", 64'(validA), 0);
    applyStimulus(1, 17'd2, 0, 1);
    applyStimulus(1, 17'd3, 0, 1);
    applyStimulus(1, 17'd4, 0, 1);
    checkOutput("t1 result", 64'(resA), 10);
    checkOutput("t1 valid", 64'(validA), 1);
    checkOutput("t1 busy after last", 64'(busyA), 0);
    applyStimulus(0, 17'd0, 0, 1);
    checkOutput("t1 valid one cycle only", 64'(validA), 0);

    $display("[TB] four max terms with gaps");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 17'd0, 0, 1);
      applyStimulus(1, 17'h1FFFF, 0, 1);
    end
    checkOutput("t2 result", 64'(resA), 524284);
    checkOutput("t2 sat", 64'(satA), 0);
`ifdef MULTADD_ACC_SAT_EN
    expB    = 262143;
    expSatB = 1'b1;
`else
    expB    = 262140;
    expSatB = 1'b0;
`endif
    checkOutput("t5 narrow result", 64'(resB), expB);
    checkOutput("t5 narrow sat", 64'(satB), 64'(expSatB));

    $display("[TB] back-to-back frames with ready low");
    applyStimulus(0, 17'd0, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 17'd1, 0, 0);
    checkOutput("t3 frame A result", 64'(resA), 4);
    checkOutput("t3 drop before B", 64'(dropA), 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 17'd2, 0, 0);
    checkOutput("t3 result kept", 64'(resA), 4);
    checkOutput("t3 drop", 64'(dropA), 1);
    checkOutput("t3 valid held", 64'(validA), 1);
    applyStimulus(0, 17'd0, 0, 1);
    checkOutput("t3 valid consumed", 64'(validA), 0);
    checkOutput("t3 drop sticky", 64'(dropA), 1);

    $display("[TB] clear mid-frame");
    applyStimulus(1, 17'd5, 0, 1);
    applyStimulus(1, 17'd6, 0, 1);
    applyStimulus(1, 17'd7, 1, 1);
    checkOutput("t4 busy after clear", 64'(busyA), 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 17'd1, 0, 1);
    checkOutput("t4 result", 64'(resA), 4);
    checkOutput("t4 valid", 64'(validA), 1);

    $display("[TB] reset mid-frame with a pending result");
    applyStimulus(0, 17'd0, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 17'd3, 0, 0);
    checkOutput("t6 pending result", 64'(resA), 12);
    applyStimulus(1, 17'd1, 0, 0);
    applyStimulus(1, 17'd2, 0, 0);
    iVALID = 1'b0;
    iRST   = 1'b1;
    @(posedge iCLK);
    #1;
    iRST = 1'b0;
    checkOutput("t6 result cleared", 64'(resA), 0);
    checkOutput("t6 valid cleared", 64'(validA), 0);
    checkOutput("t6 busy cleared", 64'(busyA), 0);
    checkOutput("t6 drop cleared", 64'(dropA), 0);
    checkOutput("t6 narrow result cleared", 64'(resB), 0);
    applyStimulus(1, 17'd1, 0, 1);
    applyStimulus(1, 17'd2, 0, 1);
    applyStimulus(1, 17'd3, 0, 1);
    applyStimulus(1, 17'd4, 0, 1);
    checkOutput("t6 result after reset", 64'(resA), 10);

    applyStimulus(0, 17'd0, 0, 1);
    applyStimulus(0, 17'd0, 0, 1);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/multadd_accumulator.md
Name: multadd_accumulator

Overview:
- Downstream stage of the 2-tap 8x8 multiply-add unit.
- Consumes its 17-bit unsigned sum-of-products stream and accumulates LEN consecutive valid terms into one dot-product result.
- Presents each result on a valid/ready output register for the next consumer, e.g. a filter output or readback stage.
- The upstream pipeline has no backpressure, so this block never stalls its input; it drops frames and flags them instead.

Parameters:
- DATA_W, 17: width of the incoming product sum.
- LEN, 16: terms per frame; legal range 1..65535.
- ACC_W, 21: accumulator/result width. DATA_W+clog2(LEN) is overflow-free.
- CNT_W, 16: term counter width; must satisfy 2^CNT_W > LEN.

Ports:
- iCLK  input  1  clock; all logic on its rising edge.
- iRST  input  1  synchronous, active-high reset.
- iVALID  input  1  iDATA holds a term this cycle; caller aligns it with the multiply-add's 2-cycle latency.
- iDATA  input  DATA_W  unsigned term.
- iCLEAR  input  1  abort the current frame.
- iREADY  input  1  consumer accepts oRESULT this cycle.
- oRESULT  output  ACC_W  completed dot product.
- oVALID  output  1  oRESULT holds an unconsumed result.
- oBUSY  output  1  a frame is partially accumulated (state ACCUM).
- oDROP  output  1  sticky: a completed frame was discarded.
- oSAT  output  1  result saturated; see Optional Feature.

Behaviour:
- Reset: synchronous and active-high, sampled only at the iCLK edge. The interface is fixed as one clock (iCLK) and synchronous active-high reset (iRST). iRST=1 forces:
  - state=IDLE, acc=0, cnt=0
  - oRESULT=0, oVALID=0, oBUSY=0, oDROP=0, oSAT=0
  - Reset mid-frame discards partial sum and pending output.
- State machine, two states:
  - IDLE, on iVALID: acc<=iDATA, cnt<=1. If LEN==1 the frame completes immediately; otherwise go to ACCUM.
  - ACCUM, on iVALID: acc<=acc+iDATA (zero-extended), cnt<=cnt+1. When cnt==LEN-1 the frame completes: state<=IDLE, acc<=0, cnt<=0.
  - ACCUM, iVALID=0: hold. No timeout.
- Completion:
  - Final sum = acc+iDATA, written to the output register on the same edge. oVALID rises one cycle after the last term is presented.
  - Back-to-back frames need no idle cycle.
- Output register:
  - oVALID&iREADY with no completing frame: oVALID<=0 and oRESULT holds its value.
  - Completion while oVALID=0, or while oVALID&iREADY: load the new result; oVALID=1.
  - Completion while oVALID&!iREADY: keep the old result and discard the new one; oDROP<=1 until reset.
- iCLEAR:
  - Sets acc=0, cnt=0, state=IDLE.
  - Output register, oVALID and oDROP are unaffected.
  - iCLEAR with iVALID in the same cycle: clear wins and the term is discarded; a completion in that cycle is also suppressed.
- oBUSY = (state==ACCUM).
- Width rule: without the Optional Feature, the sum wraps modulo 2^ACC_W.

Optional Feature:
- Macro: MULTADD_ACC_SAT_EN.
- Defined:
  - Each add is clamped to 2^ACC_W-1; a clamped frame sticks at the max value.
  - The frame's saturation is latched into oSAT together with oRESULT. oSAT is per-result and is reloaded at each output load.
- Undefined:
  - Adds wrap modulo 2^ACC_W.
  - oSAT is tied to 0.

Decomposition:
- Shared package multadd_pkg holds:
  - constants DATA_W=17 and the default LEN/ACC_W
  - the state enum {IDLE, ACCUM}
  - function acc_width(data_w, len) = data_w+clog2(len)
- One natural sub-module: multadd_acc_outreg, the single-entry valid/ready output register with drop detection.
- The FSM and adder stay in the top module.

Test Plan:
1. LEN=4, iREADY=1, terms 1,2,3,4 on consecutive cycles -> oRESULT=10 with oVALID high for exactly 1 cycle, one cycle after term 4; oBUSY high during terms 2-4.
2. LEN=4, terms 0x1FFFF four times with gaps of iVALID=0 between them -> oRESULT=524284, oSAT=0.
3. LEN=4, iREADY=0, frame A (1,1,1,1) then frame B (2,2,2,2) back-to-back -> oRESULT stays 4, oDROP=1. Then iREADY=1 for one cycle -> oVALID=0 and oDROP stays 1.
4. LEN=4, terms 5,6, then iCLEAR together with iVALID=7, then 1,1,1,1 -> oRESULT=4, oBUSY=0 the cycle after the clear.
5. LEN=4, ACC_W=18, four terms of 0x1FFFF:
   - with MULTADD_ACC_SAT_EN -> oRESULT=262143, oSAT=1
   - without it -> oRESULT=262140, oSAT=0
6. iRST asserted after two terms of a frame and with a result pending -> next cycle all outputs 0. A new frame 1,2,3,4 then yields 10.
